branch_hazard_unit: RTL and testbench
=====================================

// Module: branch_hazard_unit
// PURPOSE
//  Decides, every cycle, what the fetch program counter does next: advance, hold, or branch.
//  Sits between ID/EX and the PC; drives the PC's stall, succ and new_addr inputs.
//  - Resolves conditional branches and JAL in ID.
//  - Detects load-use hazards and requests stalls.
//  - Flushes the wrong-path instructions fetched after a taken branch.
// PARAMETERS
//  XLEN          32  register/operand width
//  FLUSH_CYCLES  2   cycles flush stays high after a taken branch (1..7)
// PORTS
//  clock        in   1     pipeline clock; all state updates on posedge
//  reset        in   1     synchronous, active-high; sampled on posedge clock only
//  id_valid     in   1     ID stage holds a real instruction
//  id_opcode    in   7     ID opcode [6:0]
//  id_funct3    in   3     ID funct3
//  id_rs1       in   5     ID source register 1 index
//  id_rs2       in   5     ID source register 2 index
//  id_rs1_val   in   XLEN  forwarded rs1 value
//  id_rs2_val   in   XLEN  forwarded rs2 value
//  id_imm       in   32    sign-extended B/J immediate, byte offset
//  ex_is_load   in   1     EX stage holds a load
//  ex_rd        in   5     EX stage destination register
//  succ         out  1     taken-branch pulse to PC
//  new_addr     out  32    byte offset to PC; valid when succ=1
//  stall        out  1     PC hold request
//  flush        out  1     squash IF/ID contents
//  misalign     out  1     misaligned-target flag; constant 0 without MISALIGN_TRAP_EN
// BEHAVIOUR
//  Outputs and timing
//  - All outputs registered: one cycle from sampled inputs to outputs.
//  - Reset: succ=0, stall=0, flush=0, misalign=0, new_addr=0, state=IDLE, flush counter=0.
//  Hazard and branch decisions
//  - hazard = ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
//  - take = id_valid & (JAL 1101111 | (BRANCH 1100011 & cond)).
//  - cond by funct3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
//    Other funct3 values give not taken.
//  State machine: IDLE, STALL, FLUSH
//  - IDLE, hazard: stall=1 next cycle; go to STALL; branch NOT resolved (operand stale).
//    Hazard wins over take when both are true.
//  - IDLE, take & !hazard: succ=1 and new_addr=id_imm for exactly one cycle.
//    flush=1 in the same cycle; go to FLUSH; counter=FLUSH_CYCLES-1.
//  - IDLE, otherwise: all pulses 0.
//  - STALL: stall=0 next cycle; return to IDLE; ID re-evaluated (one-cycle bubble only).
//  - FLUSH: flush=1; succ=0, stall=0; id_valid/hazard/take ignored (wrong path).
//    Counter decrements; go to IDLE when it reaches 0.
//  - Total flush high time = FLUSH_CYCLES consecutive cycles starting with the succ cycle.
//  Boundaries
//  - new_addr passes id_imm unmodified; the PC applies >>2 and the -1 pipeline correction.
//  - Negative offsets are passed as two's complement.
//  - succ never asserts on two consecutive cycles.
//  - stall and succ are never high together.
//  - reset has priority in any state, including mid-FLUSH: outputs clear on the next edge.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//  - take with id_imm[1:0]!=0 gives misalign=1 (one cycle), succ=0, flush=0; state stays IDLE.
//  MISALIGN_TRAP_EN undefined:
//  - misalign tied 0; branch taken normally; low bits dropped by the PC shift.
// STRUCTURE
//  - rv_pipe_pkg (shared): opcode constants OP_BRANCH, OP_JAL, OP_LOAD.
//  - rv_pipe_pkg also holds funct3 constants F3_BEQ..F3_BGEU and the bhu_state_t enum.
//  - Sub-module branch_compare: combinational.
//    Inputs (funct3, rs1_val, rs2_val); output cond; shared later with the EX-stage resolver.
// TESTING
//  1. BEQ rs1=5 rs2=5 imm=16 -> next cycle succ=1 new_addr=16.
//     flush=1 for 2 cycles, then IDLE.
//  2. BLT rs1=0xFFFFFFFF rs2=1 -> taken; BLTU same operands -> succ stays 0.
//  3. ex_is_load=1 ex_rd=3 id_rs1=3 -> stall=1 for exactly one cycle.
//     Same stimulus with ex_rd=0 -> stall=0.
//  4. Hazard + taken BNE same cycle -> stall first, succ=0.
//     After the stall, operands fixed -> succ=1 the following cycle.
//  5. Taken branch, then another taken JAL during FLUSH -> JAL ignored; only one succ pulse.
//  6. Reset asserted in 2nd FLUSH cycle -> all outputs 0 next edge.
//     Then a BEQ resolves normally.
//  7. imm=6 taken -> with MISALIGN_TRAP_EN: misalign=1, succ=0.
//     Without MISALIGN_TRAP_EN: succ=1, new_addr=6.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: opcodes, branch funct3 codes and the
// branch/hazard unit state type.
package rv_pipe_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } bhu_state_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator. Kept separate so the EX-stage
// resolver can reuse the exact same comparison rules.
module branch_compare
    import rv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            cond
);

    // Select the comparison named by funct3; reserved encodings never branch
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (rs1_val == rs2_val);
            F3_BNE:  cond = (rs1_val != rs2_val);
            F3_BLT:  cond = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  cond = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: cond = (rs1_val <  rs2_val);
            F3_BGEU: cond = (rs1_val >= rs2_val);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_hazard_unit.sv
// Branch/hazard unit: resolves branches and JAL in ID, requests a one-cycle
// stall on load-use hazards and holds flush high while wrong-path fetches
// drain. All outputs are registered.
// Optional feature macro: MISALIGN_TRAP_EN (flag taken targets whose low
// two offset bits are non-zero instead of branching).
module branch_hazard_unit
    import rv_pipe_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [31:0]     id_imm,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    output logic            succ,
    output logic [31:0]     new_addr,
    output logic            stall,
    output logic            flush,
    output logic            misalign
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    bhu_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        succ_q, succ_d;
    logic        stall_q, stall_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;
    logic [31:0] new_addr_q, new_addr_d;

    logic cond;
    logic hazard;
    logic take;
    logic bad_target;

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .funct3  (id_funct3),
        .rs1_val (id_rs1_val),
        .rs2_val (id_rs2_val),
        .cond    (cond)
    );

    assign hazard = id_valid & ex_is_load & (ex_rd != 5'd0)
                  & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign take   = id_valid & ((id_opcode == OP_JAL)
                  | ((id_opcode == OP_BRANCH) & cond));

`ifdef MISALIGN_TRAP_EN
    assign bad_target = (id_imm[1:0] != 2'b00);
`else
    assign bad_target = 1'b0;
`endif

    // Next-state and next-output decision; a hazard beats a taken branch
    // because the compared operand is still stale
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        succ_d     = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        new_addr_d = new_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (hazard) begin
                    stall_d = 1'b1;
                    state_d = ST_STALL;
                end else if (take) begin
                    if (bad_target) begin
                        misalign_d = 1'b1;
                    end else begin
                        succ_d     = 1'b1;
                        flush_d    = 1'b1;
                        new_addr_d = id_imm;
                        cnt_d      = FLUSH_LAST;
                        state_d    = (FLUSH_LAST == 3'd0) ? ST_IDLE : ST_FLUSH;
                    end
                end
            end
            ST_STALL: begin
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and output registers; reset wins in every state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            succ_q     <= 1'b0;
            stall_q    <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            new_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            succ_q     <= succ_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
            new_addr_q <= new_addr_d;
        end
    end

    assign succ     = succ_q;
    assign stall    = stall_q;
    assign flush    = flush_q;
    assign misalign = misalign_q;
    assign new_addr = new_addr_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Scoreboard bench for branch_hazard_unit: directed scenarios followed by
// random traffic, each cycle's expected outputs produced by a reference model.
module tb_branch_hazard_unit;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;

    localparam logic [6:0] OPB = 7'b1100011;
    localparam logic [6:0] OPJ = 7'b1101111;
    localparam logic [6:0] OPA = 7'b0110011;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        succ;
    logic [31:0] new_addr;
    logic        stall;
    logic        flush;
    logic        misalign;

    typedef struct packed {
        logic        succ;
        logic        stall;
        logic        flush;
        logic        misalign;
        logic [31:0] new_addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   flush_left   = 0;
    bit   bubble_next  = 0;

    branch_hazard_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clock      (clock),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_funct3  (id_funct3),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_val (id_rs1_val),
        .id_rs2_val (id_rs2_val),
        .id_imm     (id_imm),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .succ       (succ),
        .new_addr   (new_addr),
        .stall      (stall),
        .flush      (flush),
        .misalign   (misalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Architectural branch condition straight from the ISA definition
    function automatic bit branch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 0;
        endcase
    endfunction

    // Reference model: predict the outputs seen after the coming edge
    function automatic exp_t model_step();
        exp_t e;
        bit   hz;
        bit   tk;
        e = '0;
        if (reset) begin
            flush_left  = 0;
            bubble_next = 0;
        end else if (flush_left > 0) begin
            e.flush    = 1;
            flush_left = flush_left - 1;
        end else if (bubble_next) begin
            bubble_next = 0;
        end else begin
            hz = id_valid && ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
            tk = id_valid && (id_opcode == OPJ ||
                 (id_opcode == OPB && branch_taken(id_funct3, id_rs1_val, id_rs2_val)));
            if (hz) begin
                e.stall     = 1;
                bubble_next = 1;
            end else if (tk) begin
`ifdef MISALIGN_TRAP_EN
                if (id_imm % 4 != 0) begin
                    e.misalign = 1;
                end else begin
                    e.succ     = 1;
                    e.flush    = 1;
                    e.new_addr = id_imm;
                    flush_left = FLUSH_CYCLES - 1;
                end
`else
                e.succ     = 1;
                e.flush    = 1;
                e.new_addr = id_imm;
                flush_left = FLUSH_CYCLES - 1;
`endif
            end
        end
        return e;
    endfunction

    // Drive one cycle of inputs away from the active edge and queue the prediction
    task automatic applyStimulus(input logic rst, input logic vld, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                                 input logic ld, input logic [4:0] rd);
        @(negedge clock);
        reset      = rst;
        id_valid   = vld;
        id_opcode  = op;
        id_funct3  = f3;
        id_rs1     = r1;
        id_rs2     = r2;
        id_rs1_val = v1;
        id_rs2_val = v2;
        id_imm     = imm;
        ex_is_load = ld;
        ex_rd      = rd;
        exp_q.push_back(model_step());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, OPA, 3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 5'd0);
    endtask

    // Compare one registered output set against its prediction
    task automatic checkOutput(input exp_t e);
        exp_t act;
        bit   bad;
        act = '{succ, stall, flush, misalign, new_addr};
        bad = (act.succ !== e.succ) || (act.stall !== e.stall) ||
              (act.flush !== e.flush) || (act.misalign !== e.misalign) ||
              (e.succ && act.new_addr !== e.new_addr);
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("[TB] FAIL outputs t=%0t: got succ=%b stall=%b flush=%b misalign=%b new_addr=%h, expected succ=%b stall=%b flush=%b misalign=%b new_addr=%h",
                     $time, act.succ, act.stall, act.flush, act.misalign, act.new_addr,
                     e.succ, e.stall, e.flush, e.misalign, e.new_addr);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled just after the edge
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    // Guard against a hung run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] vals[5];
        logic [6:0]  op;
        logic [31:0] imm;
        vals[0] = 32'd0;
        vals[1] = 32'd1;
        vals[2] = 32'hFFFF_FFFF;
        vals[3] = 32'h8000_0000;

        // Reset state
        applyStimulus(1, 0, OPA, 3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 5'd0);
        applyStimulus(1, 0, OPA, 3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 5'd0);
        idle_cycles(1);

        // BEQ equal operands: succ with offset 16, then flush drains
        applyStimulus(0, 1, OPB, 3'b000, 5'd1, 5'd2, 32'd5, 32'd5, 32'd16, 0, 5'd0);
        idle_cycles(3);

        // Signed vs unsigned less-than on the same operands
        applyStimulus(0, 1, OPB, 3'b100, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 0, 5'd0);
        idle_cycles(2);
        applyStimulus(0, 1, OPB, 3'b110, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 0, 5'd0);
        idle_cycles(1);

        // Load-use hazard, then the same with ex_rd = x0
        applyStimulus(0, 1, OPA, 3'b000, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 1, 5'd3);
        idle_cycles(2);
        applyStimulus(0, 1, OPA, 3'b000, 5'd0, 5'd4, 32'd0, 32'd0, 32'd0, 1, 5'd0);
        idle_cycles(1);

        // Hazard together with a taken BNE, then resolved with fixed operands
        applyStimulus(0, 1, OPB, 3'b001, 5'd3, 5'd4, 32'd1, 32'd2, 32'd40, 1, 5'd3);
        applyStimulus(0, 1, OPB, 3'b001, 5'd3, 5'd4, 32'd7, 32'd2, 32'd40, 0, 5'd0);
        applyStimulus(0, 1, OPB, 3'b001, 5'd3, 5'd4, 32'd7, 32'd2, 32'd40, 0, 5'd0);
        idle_cycles(3);

        // Taken branch, JALs arriving on the wrong path are ignored
        applyStimulus(0, 1, OPB, 3'b101, 5'd1, 5'd2, 32'd9, 32'd9, 32'hFFFF_FFF0, 0, 5'd0);
        applyStimulus(0, 1, OPJ, 3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd100, 0, 5'd0);
        applyStimulus(0, 1, OPJ, 3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd100, 0, 5'd0);
        idle_cycles(2);

        // Reset while flushing, then a normal BEQ
        applyStimulus(0, 1, OPJ, 3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd64, 0, 5'd0);
        applyStimulus(1, 1, OPJ, 3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd64, 0, 5'd0);
        applyStimulus(0, 1, OPB, 3'b000, 5'd1, 5'd2, 32'd3, 32'd3, 32'd24, 0, 5'd0);
        idle_cycles(3);

        // Offset with non-zero low bits
        applyStimulus(0, 1, OPJ, 3'b000, 5'd0, 5'd0, 32'd0, 32'd0, 32'd6, 0, 5'd0);
        idle_cycles(3);

        // Random traffic biased toward branches and hazards
        for (int n = 0; n < 2000; n++) begin
            vals[4] = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    op = OPB;
                2:       op = OPJ;
                default: op = OPA;
            endcase
            imm = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) imm[1:0] = 2'($urandom_range(1, 3));
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0), op,
                          3'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)], imm,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
